// File: rtl/encoder8x3_seq.sv
// Registered 8-to-3 priority encoder with a sticky pending set and a valid/ready output slot.
// Optional macro ROUND_ROBIN_EN replaces fixed highest-index priority with a rotating search.
module encoder8x3_seq #(
  parameter int N      = 8,
  parameter int CODE_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [N-1:0]      req,
  input  logic              ready,
  output logic              valid,
  output logic [CODE_W-1:0] code,
  output logic [N-1:0]      pending
);

  logic              acc;
  logic              slot_free;
  logic [N-1:0]      newr;
  logic [N-1:0]      cand;
  logic [CODE_W-1:0] start;
  logic [CODE_W-1:0] sel_idx;
  logic              sel_found;

  assign acc       = valid & ready;
  assign slot_free = ~valid | acc;
  assign newr      = en ? req : '0;
  assign cand      = pending | newr;

`ifdef ROUND_ROBIN_EN
  logic [CODE_W-1:0] rr_ptr;
  logic [CODE_W-1:0] ptr_eff;

  // The code being accepted this cycle already counts as the last one served,
  // so the next search starts just below it rather than at the stale pointer.
  assign ptr_eff = acc ? code : rr_ptr;
  assign start   = ptr_eff - CODE_W'(1);
`else
  assign start   = CODE_W'(N - 1);
`endif

  // Descending search from start, wrapping 0 -> N-1; first set bit wins.
  always_comb begin
    logic [CODE_W-1:0] idx;
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    sel_idx   = '0;
    sel_found = 1'b0;
    idx       = '0;
    for (int i = 0; i < N; i++) begin
      idx = start - CODE_W'(i);
      if (!sel_found && cand[idx]) begin
        sel_idx   = idx;
        sel_found = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid   <= 1'b0;
      code    <= '0;
      pending <= '0;
    end else if (slot_free) begin
      if (sel_found) begin
        valid   <= 1'b1;
        code    <= sel_idx;
        pending <= cand & ~(N'(1) << sel_idx);
      end else begin
        valid   <= 1'b0;
        pending <= '0;
      end
    end else begin
      pending <= cand;
    end
  end

`ifdef ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (acc) begin
      rr_ptr <= code;
    end
  end
`endif

endmodule

// File: tb/tb_encoder8x3_seq.sv
// Self-checking bench for encoder8x3_seq: a vector table for the single-request case
// plus scoreboard-driven drains for multi-hot, stall/merge, enable gating and fairness.
module tb_encoder8x3_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] req;
  logic       ready;
  logic       valid;
  logic [2:0] code;
  logic [7:0] pending;

  int checks   = 0;
  int failures = 0;

  logic [2:0] exp_q[$];

  typedef struct {
    logic       en;
    logic [7:0] req;
    logic       ready;
    logic       exp_valid;
    logic [2:0] exp_code;
    logic [7:0] exp_pending;
  } vec_t;

  vec_t vecs[8];

  encoder8x3_seq dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .ready(ready),
    .valid(valid), .code(code), .pending(pending)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit verify);
    rst = 1'b1; en = 1'b1; req = 8'hFF; ready = 1'b0;
    step();
    step();
    if (verify) begin
      check("reset_valid",   32'(valid),   32'd0);
      check("reset_code",    32'(code),    32'd0);
      check("reset_pending", 32'(pending), 32'd0);
    end
    rst = 1'b0; req = 8'h00;
  endtask

  // Hold ready high and compare each presented code against the scoreboard.
  task automatic drain(input string name, input bit expect_idle);
    int budget = 40;
    logic [2:0] exp_code;
    ready = 1'b1;
    while (exp_q.size() > 0 && budget > 0) begin
      if (valid) begin
        exp_code = exp_q.pop_front();
        check({name, "_code"}, 32'(code), 32'(exp_code));
      end
      step();
      budget--;
    end
    if (exp_q.size() > 0) begin
      check({name, "_timeout_left"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    if (expect_idle) begin
      check({name, "_idle_valid"},   32'(valid),   32'd0);
      check({name, "_idle_pending"}, 32'(pending), 32'd0);
    end
  endtask

  initial begin
    vecs[0] = '{1'b1, 8'h10, 1'b0, 1'b1, 3'd4, 8'h00};
    vecs[1] = '{1'b1, 8'h00, 1'b0, 1'b1, 3'd4, 8'h00};
    vecs[2] = '{1'b1, 8'h00, 1'b0, 1'b1, 3'd4, 8'h00};
    vecs[3] = '{1'b1, 8'h00, 1'b0, 1'b1, 3'd4, 8'h00};
    vecs[4] = '{1'b1, 8'h00, 1'b0, 1'b1, 3'd4, 8'h00};
    vecs[5] = '{1'b1, 8'h00, 1'b0, 1'b1, 3'd4, 8'h00};
    vecs[6] = '{1'b1, 8'h00, 1'b1, 1'b0, 3'd4, 8'h00};
    vecs[7] = '{1'b0, 8'h80, 1'b0, 1'b0, 3'd4, 8'h00};

    // Reset with all requests high
    do_reset(1'b1);

    // Single request, held while stalled, then accepted
    for (int i = 0; i < 8; i++) begin
      en = vecs[i].en; req = vecs[i].req; ready = vecs[i].ready;
      step();
      check($sformatf("single_row%0d_valid", i),   32'(valid),   32'(vecs[i].exp_valid));
      check($sformatf("single_row%0d_code", i),    32'(code),    32'(vecs[i].exp_code));
      check($sformatf("single_row%0d_pending", i), 32'(pending), 32'(vecs[i].exp_pending));
    end

    // Multi-hot one-cycle pulse
    do_reset(1'b0);
    en = 1'b1; req = 8'b1010_0101; ready = 1'b1;
    step();
    req = 8'h00;
    exp_q.push_back(3'd7); exp_q.push_back(3'd5);
    exp_q.push_back(3'd2); exp_q.push_back(3'd0);
    drain("multihot", 1'b1);

    // Stall and merge
    do_reset(1'b0);
    en = 1'b1; req = 8'h40; ready = 1'b0;
    step();
    check("stall_first_valid", 32'(valid), 32'd1);
    check("stall_first_code",  32'(code),  32'd6);
    step();
    check("stall_merge_code",    32'(code),    32'd6);
    check("stall_merge_pending", 32'(pending), 32'h40);
    req = 8'h02;
    step();
    check("stall_hold_code",    32'(code),    32'd6);
    check("stall_hold_valid",   32'(valid),   32'd1);
    check("stall_hold_pending", 32'(pending), 32'h42);
    req = 8'h00;
`ifdef ROUND_ROBIN_EN
    exp_q.push_back(3'd6); exp_q.push_back(3'd1); exp_q.push_back(3'd6);
`else
    exp_q.push_back(3'd6); exp_q.push_back(3'd6); exp_q.push_back(3'd1);
`endif
    drain("stall", 1'b1);

    // Enable gate, then a single enabled cycle captures all eight
    do_reset(1'b0);
    en = 1'b0; req = 8'hFF; ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("gate%0d_valid", i),   32'(valid),   32'd0);
      check($sformatf("gate%0d_pending", i), 32'(pending), 32'd0);
    end
    en = 1'b1;
    step();
    en = 1'b0; req = 8'h00;
    check("gate_capture_pending", 32'(pending), 32'h7F);
    for (int i = 7; i >= 0; i--) exp_q.push_back(3'(i));
    drain("gate", 1'b1);

    // Continuously held requests: fairness vs fixed priority
    do_reset(1'b0);
    en = 1'b1; req = 8'hFF; ready = 1'b1;
    step();
    for (int k = 0; k < 16; k++) begin
`ifdef ROUND_ROBIN_EN
      exp_q.push_back(3'(7 - (k % 8)));
`else
      exp_q.push_back(3'd7);
`endif
    end
    drain("held", 1'b0);

    // Reset wins over a handshake in the same cycle
    check("rstwin_pre_valid", 32'(valid), 32'd1);
    rst = 1'b1;
    step();
    check("rstwin_valid",   32'(valid),   32'd0);
    check("rstwin_pending", 32'(pending), 32'd0);
    check("rstwin_code",    32'(code),    32'd0);
    rst = 1'b0; req = 8'h00; en = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
